seq_detect_sched: RTL and testbench

Time-multiplexed scheduler that shares one sequence-matching datapath between `NCH` serial bit lanes. It arbitrates lanes round-robin and keeps per-lane shift history so each lane is detected independently. It holds the programmable target pattern and per-lane match counters. It sits between the serial input sources and the downstream detect consumer, replacing one detector instance per lane.

---
 rtl/seq_detect_sched_if.sv | 24 ++
 rtl/seq_detect_sched.sv | 107 ++++++++++
 tb/tb_seq_detect_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_sched_if.sv
// Serial lane stream bundle for seq_detect_sched: per-lane offer/grant plus detect pulse.
interface seq_detect_sched_if #(
    parameter int NCH = 4
) ();
    localparam int LW = $clog2(NCH);

    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_bit;
    logic [NCH-1:0] in_ready;
    logic           det_valid;
    logic [LW-1:0]  det_lane;

    // Source / consumer side
    modport master (
        output in_valid, in_bit,
        input  in_ready, det_valid, det_lane
    );

    // Scheduler side
    modport slave (
        input  in_valid, in_bit,
        output in_ready, det_valid, det_lane
    );
endinterface

// File: rtl/seq_detect_sched.sv
// Time-multiplexed sequence detector: one matching datapath shared round-robin across
// NCH serial lanes, with per-lane shift history, fill level and saturating match count.
// Optional feature macro SEQ_DETECT_SCHED_OVERLAP_EN: when defined, a match keeps its
// history so a suffix can start the next match; otherwise lane history is flushed.
module seq_detect_sched #(
    parameter int              NCH     = 4,
    parameter int              PAT_W   = 4,
    parameter int              CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 'b1011
) (
    input  logic                     clock,
    input  logic                     reset_n,
    seq_detect_sched_if.slave        bus,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [$clog2(NCH)-1:0]   rd_lane,
    output logic [CNT_W-1:0]         rd_count
);
    localparam int LW = $clog2(NCH);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]            pat;
    logic [LW-1:0]               ptr;
    logic [NCH-1:0][PAT_W-1:0]   hist;
    logic [NCH-1:0][FW-1:0]      fill;
    logic [NCH-1:0][CNT_W-1:0]   cnt;

    logic                        found;
    logic                        xfer;
    logic [LW-1:0]               gidx;
    logic [LW-1:0]               idx;
    logic [PAT_W-1:0]            hist_n;
    logic [FW-1:0]               fill_n;
    logic                        match;
    logic [CNT_W-1:0]            rd_sel;

    // Round-robin search starting at ptr; first valid lane wins
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = LW'((int'(ptr) + i) % NCH);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    // Grant is suppressed during config writes and reset so no bit is consumed then
    assign xfer         = found & ~cfg_we & reset_n;
    assign bus.in_ready = xfer ? (NCH'(1) << gidx) : '0;

    // Shared datapath: next history/fill of the granted lane and the match decision
    always_comb begin
        hist_n = {hist[gidx][PAT_W-2:0], bus.in_bit[gidx]};
        fill_n = (fill[gidx] == FW'(PAT_W)) ? fill[gidx] : fill[gidx] + FW'(1);
        match  = xfer && (fill_n == FW'(PAT_W)) && (hist_n == pat);
        rd_sel = (int'(rd_lane) < NCH) ? cnt[rd_lane] : '0;
    end

    // State update: config flush has priority over any transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat           <= RST_PAT;
            ptr           <= '0;
            hist          <= '0;
            fill          <= '0;
            cnt           <= '0;
            bus.det_valid <= 1'b0;
            bus.det_lane  <= '0;
            rd_count      <= '0;
        end else begin
            // Read sees the counter before any increment on this edge
            rd_count <= rd_sel;
            if (cfg_we) begin
                pat           <= cfg_pattern;
                ptr           <= '0;
                hist          <= '0;
                fill          <= '0;
                cnt           <= '0;
                bus.det_valid <= 1'b0;
            end else begin
                bus.det_valid <= match;
                if (xfer) begin
                    ptr <= (gidx == LW'(NCH - 1)) ? '0 : gidx + LW'(1);
                    if (match) begin
                        bus.det_lane <= gidx;
                        if (!(&cnt[gidx]))
                            cnt[gidx] <= cnt[gidx] + CNT_W'(1);
`ifdef SEQ_DETECT_SCHED_OVERLAP_EN
                        hist[gidx] <= hist_n;
                        fill[gidx] <= FW'(PAT_W);
`else
                        hist[gidx] <= '0;
                        fill[gidx] <= '0;
`endif
                    end else begin
                        hist[gidx] <= hist_n;
                        fill[gidx] <= fill_n;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: stimulus updates a queue-based lane model and
// pushes expected detections; a monitor pops and compares on every det_valid pulse.
module tb_seq_detect_sched;
    localparam int NCH   = 4;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int LW    = 2;
    localparam logic [PAT_W-1:0] RST_PAT = 4'b1011;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_DETECT_SCHED_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LW-1:0]    rd_lane = '0;
    logic [CNT_W-1:0] rd_count;

    seq_detect_sched_if #(.NCH(NCH)) bus ();

    seq_detect_sched #(.NCH(NCH), .PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(RST_PAT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .rd_lane     (rd_lane),
        .rd_count    (rd_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: per-lane queue of recent bits, pattern, counts, arbiter pointer
    int m_pat;
    int m_ptr;
    int m_cnt [NCH];
    int m_hist [NCH][$];
    int exp_q [$];
    int det_seen;
    int det_log [$];
    int act_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int p);
        m_pat = p;
        m_ptr = 0;
        for (int l = 0; l < NCH; l++) begin
            m_cnt[l] = 0;
            m_hist[l].delete();
        end
    endtask

    // One cycle, called at a falling edge; returns at the next falling edge
    task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                        input logic cw = 1'b0, input logic [PAT_W-1:0] cp = '0,
                        input int rl = -1);
        int g;
        int exp_rd;
        int val;
        bus.in_valid = v;
        bus.in_bit   = b;
        cfg_we       = cw;
        cfg_pattern  = cp;
        rd_lane      = (rl < 0) ? LW'($urandom_range(0, NCH - 1)) : LW'(rl);
        #1;
        g = -1;
        if (!cw)
            for (int i = 0; i < NCH; i++)
                if (g < 0 && v[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
        chk("in_ready", bus.in_ready, (g >= 0) ? (1 << g) : 0);
        act_g = -1;
        for (int i = 0; i < NCH; i++)
            if (bus.in_ready[i]) act_g = i;
        exp_rd = m_cnt[rd_lane];
        if (cw) begin
            model_clear(int'(cp));
        end else if (g >= 0) begin
            m_hist[g].push_back(int'(b[g]));
            if (m_hist[g].size() > PAT_W) void'(m_hist[g].pop_front());
            if (m_hist[g].size() == PAT_W) begin
                val = 0;
                for (int k = 0; k < PAT_W; k++) val = val * 2 + m_hist[g][k];
                if (val == m_pat) begin
                    exp_q.push_back(g);
                    if (m_cnt[g] < CMAX) m_cnt[g]++;
                    if (!OVL) m_hist[g].delete();
                end
            end
            m_ptr = (g + 1) % NCH;
        end
        @(negedge clock);
        chk("rd_count", rd_count, exp_rd);
    endtask

    task automatic send(input int lane, input logic bt, input int rl = -1);
        logic [NCH-1:0] b;
        b = NCH'($urandom);
        b[lane] = bt;
        step(NCH'(1 << lane), b, 1'b0, '0, rl);
    endtask

    task automatic send_seq(input int lane, input logic [7:0] seq, input int n, input int rl = -1);
        for (int i = n - 1; i >= 0; i--) send(lane, seq[i], rl);
    endtask

    task automatic idle(input int rl = -1);
        step('0, '0, 1'b0, '0, rl);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_det_valid"}, bus.det_valid, 0);
        chk({tag, "_det_lane"}, bus.det_lane, 0);
        chk({tag, "_rd_count"}, rd_count, 0);
    endtask

    // Monitor: every detect pulse must match the next expected lane, none may be missed
    always @(posedge clock) begin
        #1;
        if (reset_n) begin
            if (bus.det_valid) begin
                det_seen++;
                det_log.push_back(int'(bus.det_lane));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL det_spurious: det_valid=1 lane %0d expected no detect at %0t",
                             bus.det_lane, $time);
                end else begin
                    chk("det_lane", bus.det_lane, exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                chk("det_missing", bus.det_valid, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int rr2 [4] = '{2, 0, 2, 0};
        int li_cnt [4] = '{1, 0, 1, 0};
        logic [NCH-1:0] bb;
        bus.in_valid = '0;
        bus.in_bit   = '0;
        model_clear(int'(RST_PAT));

        // Reset held with random inputs: all outputs stay zero
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.in_valid = NCH'($urandom);
            bus.in_bit   = NCH'($urandom);
            cfg_we       = 1'($urandom);
            cfg_pattern  = PAT_W'($urandom);
            rd_lane      = LW'($urandom);
            #1;
            check_outputs_zero("reset");
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_clear(int'(RST_PAT));
        det_seen = 0;
        send_seq(0, 8'b1011, 4);
        idle();
        chk("rst_pat_det", det_seen, 1);

        // Overlap behaviour on lane 0
        step('0, '0, 1'b1, 4'b1011);
        det_seen = 0;
        send_seq(0, 8'b1011011, 7);
        idle();
        chk("ovl_dets", det_seen, OVL ? 2 : 1);
        idle(0);
        chk("ovl_cnt", rd_count, OVL ? 2 : 1);

        // Round-robin fairness
        step('0, '0, 1'b1, 4'b1011);
        for (int i = 0; i < 12; i++) begin
            step(4'b1111, NCH'($urandom));
            chk("rr_all", act_g, i % 4);
        end
        send(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0101, NCH'($urandom));
            chk("rr_0101", act_g, rr2[i]);
        end

        // Lane independence: lanes 0 and 2 interleave 1,0,1,1
        step('0, '0, 1'b1, 4'b1011);
        det_seen = 0;
        det_log.delete();
        for (int k = 0; k < 8; k++) begin
            bb = '0;
            bb[0] = RST_PAT[3 - k / 2];
            bb[2] = RST_PAT[3 - k / 2];
            step(4'b0101, bb);
        end
        idle();
        chk("li_dets", det_seen, 2);
        if (det_log.size() == 2) begin
            chk("li_first", det_log[0], 0);
            chk("li_second", det_log[1], 2);
        end else begin
            chk("li_log_size", det_log.size(), 2);
        end
        for (int l = 0; l < NCH; l++) begin
            idle(l);
            chk("li_cnt", rd_count, li_cnt[l]);
        end

        // Config write mid-stream: counts cleared, offered bit not consumed
        send_seq(0, 8'b101, 3);
        step(4'b0001, 4'b0001, 1'b1, 4'b0110);
        for (int l = 0; l < NCH; l++) begin
            idle(l);
            chk("cfg_cnt_clr", rd_count, 0);
        end
        det_seen = 0;
        send(0, 1'b1);
        idle();
        chk("cfg_no_det", det_seen, 0);
        send_seq(0, 8'b0110, 4);
        idle();
        chk("cfg_one_det", det_seen, 1);

        // Saturation on lane 1, then asynchronous reset between edges
        step('0, '0, 1'b1, 4'b1011);
        for (int m = 0; m < 5; m++) send_seq(1, 8'b1011, 4, 1);
        chk("sat_cnt", rd_count, 3);
        chk("sat_det_pulse", bus.det_valid, 1);
        bus.in_valid = 4'b0010;
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async");
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        model_clear(int'(RST_PAT));
        for (int l = 0; l < NCH; l++) begin
            idle(l);
            chk("post_rst_cnt", rd_count, 0);
        end

        // Randomized traffic with occasional reconfiguration
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 40) == 0)
                step(NCH'($urandom), NCH'($urandom), 1'b1, PAT_W'($urandom));
            else
                step(NCH'($urandom), NCH'($urandom));
        end
        idle();
        idle();
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
